io_loopback_bist: RTL and testbench

Parametrised built-in self-test engine for the bidirectional user IO bank of a tt_um user project. It drives a selectable test pattern onto the IO output path with output enables asserted, compares the looped-back input path against a latency-aligned copy of the expected pattern, and reports pass/fail, an error count and the index of the first mismatch. It sits beside the user logic inside the tt_um top and is muxed onto uio_out/uio_oe while busy. It is the generalised successor to the fixed 8-bit pin hookup: width, loopback latency and counter width are configurable, and the pattern modes are new.

---
 rtl/io_loopback_bist.sv | 205 ++++++++++++++++++++
 tb/tb_io_loopback_bist.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_loopback_bist.sv
// io_loopback_bist: built-in self-test for a bidirectional IO bank.
// Drives a selectable pattern (counter, walking-one, PRBS, checkerboard) onto
// pat_out with all output enables set. The looped-back pat_in is compared with
// a latency-aligned copy of the expected pattern. The block reports pass/fail,
// a saturating error count and the index of the first mismatch.
// Optional feature: define IO_BIST_INJECT_EN to add an 'inject' input. While it
// is high during DRIVE, bit 0 of pat_out is inverted. The expected value is not
// inverted, so the checker must flag the error.
module io_loopback_bist #(
  parameter int          WIDTH = 8,
  parameter int          LAT   = 2,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] length,
`ifdef IO_BIST_INJECT_EN
  input  logic             inject,
`endif
  output logic [WIDTH-1:0] pat_out,
  output logic [WIDTH-1:0] pat_oe,
  input  logic [WIDTH-1:0] pat_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t           state;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] walk;
  logic [15:0]      lfsr;
  logic [3:0]       drain_cnt;
  logic [WIDTH-1:0] pat_r;
  logic             drv_r;

  // Expected-value delay line: stage 0 is aligned with pat_out, stage LAT with pat_in.
  logic [WIDTH-1:0] exp_p [0:LAT];
  logic [CNT_W-1:0] idx_p [0:LAT];
  logic [LAT:0]     vld_p;

  logic             accept;
  logic             present;
  logic [1:0]       cur_mode;
  logic [CNT_W-1:0] cur_idx;
  logic [WIDTH-1:0] cur_walk;
  logic [15:0]      cur_lfsr;
  logic [WIDTH-1:0] gen_pat;
  logic             mism;
  logic [CNT_W-1:0] err_next;

  // x^16+x^14+x^13+x^11+1, Fibonacci form, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < WIDTH; j++) r[(j + 1) % WIDTH] = w[j];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pattern(input logic [1:0]       m,
                                                input logic [CNT_W-1:0] i,
                                                input logic [WIDTH-1:0] w,
                                                input logic [15:0]      s);
    logic [31:0]      wide;
    logic [WIDTH-1:0] p;
    wide = 32'(i);
    p    = '0;
    case (m)
      2'd0: p = wide[WIDTH-1:0];
      2'd1: p = w;
      2'd2: p = s[WIDTH-1:0];
      default: for (int j = 0; j < WIDTH; j++) p[j] = (j % 2 == 0) ? ~i[0] : i[0];
    endcase
    return p;
  endfunction

  // Generator inputs: a run that is starting uses the initial generator state.
  always_comb begin
    accept   = start && (state == IDLE || state == DONE);
    cur_mode = accept ? mode : mode_r;
    cur_idx  = accept ? '0 : idx;
    cur_walk = accept ? WIDTH'(1) : walk;
    cur_lfsr = accept ? SEED : lfsr;
    present  = accept ? (length != '0) : (state == DRIVE && idx != len_r);
    gen_pat  = pattern(cur_mode, cur_idx, cur_walk, cur_lfsr);
    mism     = vld_p[LAT] && (pat_in != exp_p[LAT]);
    err_next = err_count;
    if (accept)
      err_next = '0;
    else if (mism && err_count != '1)
      err_next = err_count + CNT_W'(1);
  end

`ifdef IO_BIST_INJECT_EN
  assign pat_out = pat_r ^ WIDTH'(inject & drv_r);
`else
  assign pat_out = pat_r;
`endif

  // Control FSM, generator state, registered outputs and the checker results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mode_r        <= 2'd0;
      len_r         <= '0;
      idx           <= '0;
      walk          <= WIDTH'(1);
      lfsr          <= SEED;
      drain_cnt     <= 4'd0;
      pat_r         <= '0;
      drv_r         <= 1'b0;
      pat_oe        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '1;
      vld_p         <= '0;
    end else begin
      done      <= 1'b0;
      err_count <= err_next;
      if (accept)
        first_err_idx <= '1;
      else if (mism && err_count == '0)
        first_err_idx <= idx_p[LAT];

      vld_p <= {vld_p[LAT-1:0], present};

      if (present) begin
        pat_r <= gen_pat;
        drv_r <= 1'b1;
        idx   <= cur_idx + CNT_W'(1);
        walk  <= rotl1(cur_walk);
        lfsr  <= lfsr_step(cur_lfsr);
      end else begin
        pat_r <= '0;
        drv_r <= 1'b0;
        if (accept) begin
          idx  <= '0;
          walk <= WIDTH'(1);
          lfsr <= SEED;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_r <= mode;
            len_r  <= length;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state  <= DRIVE;
              busy   <= 1'b1;
              pat_oe <= '1;
            end
          end
        end
        DRIVE: begin
          if (idx == len_r) begin
            state     <= DRAIN;
            drain_cnt <= 4'd0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'(LAT - 1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            pat_oe <= '0;
            done   <= 1'b1;
            pass   <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expected data and index shift along with vld_p; qualified by vld_p, so no reset.
  always_ff @(posedge clk) begin
    exp_p[0] <= gen_pat;
    idx_p[0] <= cur_idx;
    for (int s = 1; s <= LAT; s++) begin
      exp_p[s] <= exp_p[s-1];
      idx_p[s] <= idx_p[s-1];
    end
  end

endmodule

// File: tb/tb_io_loopback_bist.sv
// Self-checking bench for io_loopback_bist: WIDTH=8, LAT=2 loopback with
// optional lane faults, plus a CNT_W=4 instance with pat_in tied low.
module tb_io_loopback_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] length;
  logic [7:0]  pat_out, pat_oe, pat_in;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic        inject;

  logic        start4;
  logic [1:0]  mode4;
  logic [3:0]  length4;
  logic [7:0]  pat_out4, pat_oe4;
  logic [7:0]  pat_in4 = 8'h00;
  logic        busy4, done4, pass4;
  logic [3:0]  err4, first4;

  logic [7:0]  d1, d2;
  int          fault;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  io_loopback_bist #(.WIDTH(8), .LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .length(length),
`ifdef IO_BIST_INJECT_EN
    .inject(inject),
`endif
    .pat_out(pat_out), .pat_oe(pat_oe), .pat_in(pat_in), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx));

  io_loopback_bist #(.WIDTH(8), .LAT(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .length(length4),
`ifdef IO_BIST_INJECT_EN
    .inject(1'b0),
`endif
    .pat_out(pat_out4), .pat_oe(pat_oe4), .pat_in(pat_in4), .busy(busy4), .done(done4),
    .pass(pass4), .err_count(err4), .first_err_idx(first4));

  // Two-cycle external loopback with selectable lane faults.
  always_ff @(posedge clk) begin
    d1 <= pat_out;
    d2 <= d1;
  end
  assign pat_in = (fault == 2) ? 8'h00 : (fault == 1) ? (d2 & 8'hF7) : d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_pat(input logic [1:0] m, input int i);
    logic [15:0] s;
    case (m)
      2'd0: return 8'(i);
      2'd1: return 8'd1 << (i % 8);
      2'd2: begin
        s = 16'hACE1;
        for (int k = 0; k < i; k++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s[7:0];
      end
      default: return (i % 2 == 0) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  // Called at a negedge; leaves off at the negedge of the done cycle.
  task automatic run(input logic [1:0] m, input int len, input int f,
                     input int e_err, input int e_first, input bit e_pass);
    logic [7:0] e;
    fault  = f;
    start  = 1'b1;
    mode   = m;
    length = 16'(len);
    for (int i = 0; i < len; i++) sb.push_back(model_pat(m, i));
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (sb.size() == 0) e = 8'hxx; else e = sb.pop_front();
      chk("pat_out", pat_out, e);
      if (i == 0) begin
        chk("busy_rise", busy, 1);
        chk("oe_drive", pat_oe, 8'hFF);
      end
    end
    if (len > 0) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_pat", pat_out, 0);
        chk("drain_oe", pat_oe, 8'hFF);
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_oe", pat_oe, 0);
    chk("pass", pass, e_pass);
    chk("err_count", err_count, e_err);
    chk("first_err_idx", first_err_idx, e_first);
  endtask

  typedef struct {
    logic [1:0] m;
    int         len;
    int         f;
    int         e_err;
    int         e_first;
    bit         e_pass;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'd0, 10,  0, 0, 'hFFFF, 1'b1};
    vecs[1] = '{2'd1, 9,   0, 0, 'hFFFF, 1'b1};
    vecs[2] = '{2'd0, 16,  1, 8, 8,      1'b0};
    vecs[3] = '{2'd2, 40,  0, 0, 'hFFFF, 1'b1};
    vecs[4] = '{2'd3, 7,   1, 3, 1,      1'b0};
    vecs[5] = '{2'd1, 9,   1, 1, 3,      1'b0};
    vecs[6] = '{2'd0, 0,   0, 0, 'hFFFF, 1'b1};
    vecs[7] = '{2'd3, 5,   2, 5, 0,      1'b0};
    vecs[8] = '{2'd0, 300, 0, 0, 'hFFFF, 1'b1};

    rst = 1'b1; start = 1'b0; mode = 2'd0; length = '0; inject = 1'b0; fault = 0;
    start4 = 1'b0; mode4 = 2'd0; length4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_pat_out", pat_out, 0);
    chk("rst_oe", pat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_idx, 16'hFFFF);
    chk("rst_first4", first4, 4'hF);
    rst = 1'b0;
    @(negedge clk);

    // Runs are chained: each start lands in the done cycle of the previous run.
    for (int v = 0; v < 9; v++)
      run(vecs[v].m, vecs[v].len, vecs[v].f, vecs[v].e_err, vecs[v].e_first, vecs[v].e_pass);

    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("pass_hold", pass, 1);

    // start while busy must be ignored.
    fault = 0; start = 1'b1; mode = 2'd0; length = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_pat0", pat_out, 8'h00);
    start = 1'b1; mode = 2'd1; length = 16'd0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("ign_pat", pat_out, 8'(i));
    end
    repeat (2) @(negedge clk);
    chk("ign_busy", busy, 1);
    @(negedge clk);
    chk("ign_done", done, 1);
    chk("ign_err", err_count, 0);

    // Asynchronous reset in the middle of a failing run.
    @(negedge clk);
    fault = 2; start = 1'b1; mode = 2'd3; length = 16'd30;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_err", err_count, 3);
    chk("mid_first", first_err_idx, 0);
    rst = 1'b1;
    #1;
    chk("arst_oe", pat_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_count, 0);
    chk("arst_pat", pat_out, 0);
    chk("arst_first", first_err_idx, 16'hFFFF);
    chk("arst_pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;
    run(2'd0, 3, 0, 0, 'hFFFF, 1'b1);

    // Narrow counters with pat_in tied low: every pattern mismatches.
    @(negedge clk);
    start4 = 1'b1; mode4 = 2'd3; length4 = 4'd15;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (17) @(negedge clk);
    chk("c4_busy", busy4, 1);
    @(negedge clk);
    chk("c4_done", done4, 1);
    chk("c4_err", err4, 4'hF);
    chk("c4_first", first4, 0);
    chk("c4_pass", pass4, 0);

`ifdef IO_BIST_INJECT_EN
    // Inject a single-bit error at index 7 of a PRBS run.
    @(negedge clk);
    fault = 0; start = 1'b1; mode = 2'd2; length = 16'd50;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      inject = (i == 7);
    end
    inject = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("inj_done", done, 1);
    chk("inj_err", err_count, 1);
    chk("inj_first", first_err_idx, 7);
    chk("inj_pass", pass, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
